sub_bcd_converter: RTL

SUB_BCD_CONVERTER -- requirements
Module: sub_bcd_converter

---
 rtl/sub_bcd_converter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/sub_bcd_converter.sv
// sub_bcd_converter: signed 9-bit subtractor result to sign + 3 BCD digits via iterative double-dabble.
// Optional 7-segment decode of the registered digits when SUB_BCD_SEG_EN is defined.
module sub_bcd_converter #(
    parameter bit LEAD_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [8:0] s,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       neg,
    output logic [3:0] hund,
    output logic [3:0] tens,
    output logic [3:0] ones
`ifdef SUB_BCD_SEG_EN
    ,
    output logic [6:0] seg_h,
    output logic [6:0] seg_t,
    output logic [6:0] seg_o,
    output logic       seg_neg
`endif
);
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [8:0]  m_q;
    logic [11:0] bcd_q;
    logic        neg_p_q, neg_q, in_ready_q, out_valid_q;
    logic [3:0]  hund_q, tens_q, ones_q;
    logic [8:0]  mag;
    logic [11:0] adj, bcd_d;
    logic [8:0]  m_d;
    logic [3:0]  hund_d, tens_d;
    always_comb begin
        mag     = s[8] ? 9'd256 - {1'b0, s[7:0]} : {1'b0, s[7:0]};
        adj     = {bcd_q[11:8] >= 4'd5 ? bcd_q[11:8] + 4'd3 : bcd_q[11:8],
                   bcd_q[7:4]  >= 4'd5 ? bcd_q[7:4]  + 4'd3 : bcd_q[7:4],
                   bcd_q[3:0]  >= 4'd5 ? bcd_q[3:0]  + 4'd3 : bcd_q[3:0]};
        bcd_d   = {adj[10:0], m_q[8]};
        // adj[11] is always 0 for a 9-bit magnitude; recirculating it keeps every bit used
        m_d     = {m_q[7:0], adj[11]};
        hund_d  = (LEAD_BLANK && bcd_d[11:8] == 4'd0) ? 4'hF : bcd_d[11:8];
        tens_d  = (LEAD_BLANK && bcd_d[11:4] == 8'd0) ? 4'hF : bcd_d[7:4];
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            m_q         <= '0;
            bcd_q       <= '0;
            neg_p_q     <= 1'b0;
            neg_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            hund_q      <= '0;
            tens_q      <= '0;
            ones_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        neg_p_q    <= s[8];
                        m_q        <= mag;
                        bcd_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CONV;
                    end
                end
                CONV: begin
                    bcd_q <= bcd_d;
                    m_q   <= m_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd8) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        neg_q       <= neg_p_q;
                        hund_q      <= hund_d;
                        tens_q      <= tens_d;
                        ones_q      <= bcd_d[3:0];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign neg       = neg_q;
    assign hund      = hund_q;
    assign tens      = tens_q;
    assign ones      = ones_q;
`ifdef SUB_BCD_SEG_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction
    assign seg_h   = seg7(hund_q);
    assign seg_t   = seg7(tens_q);
    assign seg_o   = seg7(ones_q);
    assign seg_neg = neg_q;
`endif
endmodule
